// File: rtl/serial_chunk_adder.sv
// rtl/serial_chunk_adder.sv - multi-cycle WIDTH-bit adder, CHUNK bits per clock
//
// Computes S = A + B + C (unsigned modulo 2^WIDTH) in WIDTH/CHUNK RUN cycles.
// Ports:
//   CLK, RST            clock, asynchronous active-high reset
//   START               request, sampled only in IDLE
//   A, B, C             operands and carry-in, latched on the accepting edge
//   S, CO, OVF          registered sum, carry-out, signed overflow
//   BUSY                high while not IDLE
//   DONE                one-cycle pulse marking a new result
module serial_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C,
  output logic [WIDTH-1:0] S,
  output logic             CO,
  output logic             OVF,
  output logic             BUSY,
  output logic             DONE
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK:0]         chunk_sum;
  logic [WIDTH+CHUNK-1:0] res_wide;
  logic [WIDTH-1:0]       res_next;

  always_comb begin
    chunk_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
    // New chunk enters at the MSB side; the wide concat keeps this legal when CHUNK == WIDTH.
    res_wide  = {chunk_sum[CHUNK-1:0], res_q};
    res_next  = res_wide[WIDTH+CHUNK-1:CHUNK];

    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    s_d     = s_q;
    co_d    = co_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d = ST_RUN;
          a_d     = A;
          b_d     = B;
          carry_d = C;
          cnt_d   = '0;
          res_d   = '0;
          // Operand registers get shifted away, so keep the sign bits for OVF.
          a_msb_d = A[WIDTH-1];
          b_msb_d = B[WIDTH-1];
        end
      end
      ST_RUN: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        res_d   = res_next;
        carry_d = chunk_sum[CHUNK];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          s_d     = res_next;
          co_d    = chunk_sum[CHUNK];
          ovf_d   = (a_msb_q == b_msb_q) && (res_next[WIDTH-1] != a_msb_q);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      s_q     <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      s_q     <= s_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
    end
  end

  assign S    = s_q;
  assign CO   = co_q;
  assign OVF  = ovf_q;
  assign BUSY = (state_q != ST_IDLE);
  assign DONE = (state_q == ST_DONE);

endmodule
